// File: rtl/decode_stage.sv
// Decode stage: register file, immediate extraction and a one-entry valid/ready output register.
// Define DECODE_BYPASS_EN to forward same-cycle register-file writes to the read ports.
module decode_stage #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 8,
    parameter int unsigned SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       instr,
    input  logic [1:0]        imm_sel,
    input  logic              zext,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a_src,
    output logic [DATA_W-1:0] b_src,
    output logic [DATA_W-1:0] imm8_out,
    output logic [DATA_W-1:0] imm11_out,
    output logic              err
);

    logic [DATA_W-1:0] regs_q [NREGS];
    logic              valid_q, valid_d;
    logic              err_q;
    logic [DATA_W-1:0] a_q, b_q, imm8_q, imm11_q;

    logic [SEL_W-1:0]  rs_idx, rt_idx;
    logic [DATA_W-1:0] rs_data, rt_data;
    logic [DATA_W-1:0] imm5_ext, imm8_ext, imm11_ext, b_next;
    logic              wr_ok, xfer;

    assign rs_idx = SEL_W'(instr[10:8]);
    assign rt_idx = SEL_W'(instr[7:5]);
    assign wr_ok  = 32'(wr_sel) < NREGS;

    // Out-of-range indices fall through the loop and read as zero.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (32'(rs_idx) == i) rs_data = regs_q[i];
            if (32'(rt_idx) == i) rt_data = regs_q[i];
        end
`ifdef DECODE_BYPASS_EN
        if (wr_en && wr_ok && rs_idx == wr_sel) rs_data = wr_data;
        if (wr_en && wr_ok && rt_idx == wr_sel) rt_data = wr_data;
`endif
    end

    assign imm5_ext  = zext ? DATA_W'(instr[4:0])
                            : {{(DATA_W-5){instr[4]}}, instr[4:0]};
    assign imm8_ext  = zext ? DATA_W'(instr[7:0])
                            : {{(DATA_W-8){instr[7]}}, instr[7:0]};
    assign imm11_ext = {{(DATA_W-11){instr[10]}}, instr[10:0]};

    always_comb begin
        b_next = rt_data;
        unique case (imm_sel)
            2'd0: b_next = rt_data;
            2'd1: b_next = imm5_ext;
            2'd2: b_next = imm8_ext;
            2'd3: b_next = imm11_ext;
            default: b_next = rt_data;
        endcase
    end

    // Flush masks in_ready, so it also blocks any transfer in the same cycle.
    assign in_ready = (!valid_q || out_ready) && !flush;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (xfer)      valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            imm8_q  <= '0;
            imm11_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (xfer) begin
                a_q     <= rs_data;
                b_q     <= b_next;
                imm8_q  <= imm8_ext;
                imm11_q <= imm11_ext;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            if (wr_en && !wr_ok) err_q <= 1'b1;
            for (int unsigned i = 0; i < NREGS; i++) begin
                if (wr_en && 32'(wr_sel) == i) regs_q[i] <= wr_data;
            end
        end
    end

    assign out_valid = valid_q;
    assign a_src     = a_q;
    assign b_src     = b_q;
    assign imm8_out  = imm8_q;
    assign imm11_out = imm11_q;
    assign err       = err_q;

endmodule
